// File: rtl/seq_hunt_pkg.sv
// Shared types and reset defaults for the serial pattern hunt controller.
package seq_hunt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HUNT = 2'd1,
      DONE = 2'd2,
      TMO  = 2'd3
   } state_t;

   localparam logic [3:0] RST_PATTERN = 4'b1010;
   localparam logic       RST_OVERLAP = 1'b0;
   localparam int         RST_TARGET  = 1;
   localparam int         RST_TIMEOUT = 0;

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern matcher: history shift register, fill count and window compare.
module seq_match_core #(
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             i,
   input  logic             i_valid,
   input  logic             clr,
   input  logic [PAT_W-1:0] pattern,
   input  logic             overlap,
   output logic             match
);

   localparam int FILL_W = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   logic [PAT_W-2:0]  history;
   logic [FILL_W-1:0] fill;
   logic [PAT_W-1:0]  window;

   assign window = {history, i};
   assign match  = en && i_valid && (fill == FILL_MAX) && (window == pattern);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         history <= '0;
         fill    <= '0;
      end else if (clr) begin
         history <= '0;
         fill    <= '0;
      end else if (en && i_valid) begin
         history <= window[PAT_W-2:0];
         // Non-overlap restart: the next match needs a full set of fresh bits.
         if (match && !overlap)
            fill <= '0;
         else if (fill != FILL_MAX)
            fill <= fill + FILL_W'(1);
      end
   end

endmodule

// File: rtl/seq_hunt_ctrl.sv
// Run control around seq_match_core: config registers, match counting,
// inter-match timeout and run status.
//
//   state | meaning
//   IDLE  | no run yet, or last run aborted
//   HUNT  | run in progress, matching serial bits
//   DONE  | target match count reached
//   TMO   | too long between matches
module seq_hunt_ctrl
   import seq_hunt_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8,
   parameter int TO_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic             cfg_overlap,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic [TO_W-1:0]  cfg_timeout,
   input  logic             start,
   input  logic             abort,
   input  logic             i,
   input  logic             i_valid,
   output logic             y,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] match_cnt
);

   state_t           state, state_nx;
   logic [PAT_W-1:0] pattern_r;
   logic             overlap_r;
   logic [CNT_W-1:0] target_r;
   logic [TO_W-1:0]  timeout_r;
   logic [TO_W-1:0]  tmr, tmr_load;
   logic [CNT_W-1:0] cnt_inc;
   logic             hunt, start_run, match_raw, hit_target, tmr_tc;

   assign hunt       = (state == HUNT);
   assign start_run  = start && !hunt;
   assign y          = match_raw && !abort;
   assign cnt_inc    = match_cnt + CNT_W'(1);
   assign hit_target = (target_r != '0) && (cnt_inc == target_r);
   assign tmr_tc     = (timeout_r != '0) && (tmr == '0);
   // A timeout written together with start must govern this run from its first cycle.
   assign tmr_load   = ((start_run && cfg_we) ? cfg_timeout : timeout_r) - TO_W'(1);

   assign busy    = hunt;
   assign done    = (state == DONE);
   assign timeout = (state == TMO);

   seq_match_core #(.PAT_W(PAT_W)) u_core (
      .clk     (clk),
      .rst     (rst),
      .en      (hunt),
      .i       (i),
      .i_valid (i_valid),
      .clr     (start_run),
      .pattern (pattern_r),
      .overlap (overlap_r),
      .match   (match_raw)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pattern_r <= PAT_W'(RST_PATTERN);
         overlap_r <= RST_OVERLAP;
         target_r  <= CNT_W'(RST_TARGET);
         timeout_r <= TO_W'(RST_TIMEOUT);
      end else if (cfg_we && !hunt) begin
         pattern_r <= cfg_pattern;
         overlap_r <= cfg_overlap;
         target_r  <= cfg_target;
         timeout_r <= cfg_timeout;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE, TMO: if (start) state_nx = HUNT;
         HUNT: begin
            if (abort)       state_nx = IDLE;
            else if (y)      state_nx = hit_target ? DONE : HUNT;
            else if (tmr_tc) state_nx = TMO;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         match_cnt <= '0;
         tmr       <= '0;
      end else if (start_run) begin
         match_cnt <= '0;
         tmr       <= tmr_load;
      end else if (hunt && !abort) begin
         if (y) begin
            if (match_cnt != '1) match_cnt <= cnt_inc;
            tmr <= tmr_load;
         end else if (tmr != '0) begin
            tmr <= tmr - TO_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_seq_hunt_ctrl.sv
// Directed bench for seq_hunt_ctrl with a bit-window reference model checked every cycle.
module tb_seq_hunt_ctrl;
   localparam int PAT_W = 4;
   localparam int CNT_W = 8;
   localparam int TO_W  = 16;
   localparam int M_IDLE = 0, M_HUNT = 1, M_DONE = 2, M_TMO = 3;

   logic             clk = 1'b0, rst = 1'b1;
   logic             cfg_we = 1'b0, cfg_overlap = 1'b0;
   logic [PAT_W-1:0] cfg_pattern = 4'b1010;
   logic [CNT_W-1:0] cfg_target = 8'd1;
   logic [TO_W-1:0]  cfg_timeout = 16'd0;
   logic             start = 1'b0, abort = 1'b0, i = 1'b0, i_valid = 1'b0;
   logic             y, busy, done, timeout;
   logic [CNT_W-1:0] match_cnt;

   int n_tests = 0, n_fail = 0;
   bit running = 1'b0;

   always #5 clk = ~clk;

   seq_hunt_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .cfg_timeout(cfg_timeout),
      .start(start), .abort(abort), .i(i), .i_valid(i_valid), .y(y), .busy(busy),
      .done(done), .timeout(timeout), .match_cnt(match_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: run mode, matches, cycles since last match, and the recent bits seen.
   int               m_mode, m_cnt, m_since;
   bit               win[$];
   logic [PAT_W-1:0] mp_pattern;
   bit               mp_overlap;
   int               mp_target, mp_timeout;

   function automatic bit model_y();
      logic [PAT_W-1:0] w;
      if (m_mode != M_HUNT || !i_valid || abort) return 1'b0;
      if (win.size() < PAT_W - 1) return 1'b0;
      for (int k = 0; k < PAT_W - 1; k++) w[PAT_W-1-k] = win[k];
      w[0] = i;
      return (w == mp_pattern);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = M_IDLE; m_cnt = 0; m_since = 0; win.delete();
         mp_pattern = 4'b1010; mp_overlap = 1'b0; mp_target = 1; mp_timeout = 0;
      end else begin
         bit my;
         my = model_y();
         if (m_mode == M_HUNT) begin
            if (abort) m_mode = M_IDLE;
            else begin
               if (i_valid) begin
                  win.push_back(i);
                  while (win.size() > PAT_W - 1) void'(win.pop_front());
               end
               if (my) begin
                  if (m_cnt < 255) m_cnt++;
                  m_since = 0;
                  if (!mp_overlap) win.delete();
                  if (mp_target != 0 && m_cnt == mp_target) m_mode = M_DONE;
               end else begin
                  m_since++;
                  if (mp_timeout != 0 && m_since == mp_timeout) m_mode = M_TMO;
               end
            end
         end else begin
            if (cfg_we) begin
               mp_pattern = cfg_pattern; mp_overlap = cfg_overlap;
               mp_target = int'(cfg_target); mp_timeout = int'(cfg_timeout);
            end
            if (start) begin
               m_mode = M_HUNT; m_cnt = 0; m_since = 0; win.delete();
            end
         end
      end
   end

   always @(negedge clk) begin
      if (running) begin
         check("cyc_y",       32'(y),         32'(model_y()));
         check("cyc_busy",    32'(busy),      32'(m_mode == M_HUNT));
         check("cyc_done",    32'(done),      32'(m_mode == M_DONE));
         check("cyc_timeout", 32'(timeout),   32'(m_mode == M_TMO));
         check("cyc_cnt",     32'(match_cnt), m_cnt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic load_cfg(input logic [3:0] p, input logic ov, input int tg, input int to);
      cfg_pattern = p; cfg_overlap = ov;
      cfg_target = CNT_W'(tg); cfg_timeout = TO_W'(to);
      cfg_we = 1'b1; tick(); cfg_we = 1'b0;
   endtask

   // Sends n bits MSB first; ymask[k] records y on the (k+1)-th bit.
   task automatic send(input logic [31:0] bits, input int n, output logic [31:0] ymask);
      ymask = '0;
      for (int k = 0; k < n; k++) begin
         i = bits[n-1-k]; i_valid = 1'b1;
         @(negedge clk);
         ymask[k] = y;
         tick();
         i_valid = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] m;
      running = 1'b1;
      tick(); tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_cnt",  32'(match_cnt), 32'd0);
      rst = 1'b0;
      tick();

      // defaults: 1010, target 1
      do_start();
      check("t1_busy", 32'(busy), 32'd1);
      send(32'b11010, 5, m);
      check("t1_ymask", m, 32'h10);
      check("t1_cnt",  32'(match_cnt), 32'd1);
      check("t1_done", 32'(done), 32'd1);
      check("t1_busy_end", 32'(busy), 32'd0);

      // non-overlap, target 3
      load_cfg(4'b1010, 1'b0, 3, 0);
      do_start();
      send(32'b1010101010, 10, m);
      check("t2_ymask10", m, 32'h088);
      check("t2_cnt10", 32'(match_cnt), 32'd2);
      check("t2_busy10", 32'(busy), 32'd1);
      send(32'b10, 2, m);
      check("t2_ymask12", m, 32'h2);
      check("t2_cnt", 32'(match_cnt), 32'd3);
      check("t2_done", 32'(done), 32'd1);

      // overlap, free-run, then abort
      load_cfg(4'b1010, 1'b1, 0, 0);
      do_start();
      send(32'b1010101010, 10, m);
      check("t3_ymask", m, 32'h2A8);
      check("t3_cnt", 32'(match_cnt), 32'd4);
      check("t3_busy", 32'(busy), 32'd1);
      abort = 1'b1; tick(); abort = 1'b0;
      check("t3_abort_busy", 32'(busy), 32'd0);
      check("t3_abort_done", 32'(done), 32'd0);
      check("t3_abort_cnt", 32'(match_cnt), 32'd4);

      // timeout 10 after one match
      load_cfg(4'b1010, 1'b0, 2, 10);
      do_start();
      send(32'b1010, 4, m);
      check("t4_ymask", m, 32'h8);
      repeat (9) tick();
      check("t4_busy9", 32'(busy), 32'd1);
      check("t4_tmo9", 32'(timeout), 32'd0);
      tick();
      check("t4_tmo", 32'(timeout), 32'd1);
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_done", 32'(done), 32'd0);
      check("t4_cnt", 32'(match_cnt), 32'd1);

      // abort on the final bit
      load_cfg(4'b1010, 1'b0, 1, 0);
      do_start();
      send(32'b101, 3, m);
      abort = 1'b1;
      send(32'b0, 1, m);
      abort = 1'b0;
      check("t5_y", m, 32'h0);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      check("t5_cnt", 32'(match_cnt), 32'd0);
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      check("t5_start_wins", 32'(busy), 32'd1);
      abort = 1'b1; tick(); abort = 1'b0;
      check("t5_abort2", 32'(busy), 32'd0);

      // cfg_we and start ignored during HUNT
      do_start();
      send(32'b10, 2, m);
      load_cfg(4'b1100, 1'b0, 1, 0);
      do_start();
      send(32'b10, 2, m);
      check("t6_ymask_hunt", m, 32'h2);
      check("t6_done", 32'(done), 32'd1);
      load_cfg(4'b1100, 1'b0, 1, 0);
      do_start();
      send(32'b10101100, 8, m);
      check("t6_ymask_1100", m, 32'h80);
      check("t6_cnt", 32'(match_cnt), 32'd1);

      // free-run counter saturation
      load_cfg(4'b1010, 1'b1, 0, 0);
      do_start();
      send(32'b10, 2, m);
      repeat (300) send(32'b10, 2, m);
      check("t7_sat", 32'(match_cnt), 32'd255);
      check("t7_busy", 32'(busy), 32'd1);

      // async reset mid-run restores defaults
      load_cfg(4'b0110, 1'b1, 5, 0);
      do_start();
      send(32'b01, 2, m);
      #2 rst = 1'b1;
      #1;
      check("t8_rst_busy", 32'(busy), 32'd0);
      check("t8_rst_cnt", 32'(match_cnt), 32'd0);
      tick();
      rst = 1'b0;
      do_start();
      send(32'b1010, 4, m);
      check("t8_ymask", m, 32'h8);
      check("t8_done", 32'(done), 32'd1);

      tick();
      running = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
